mem_port_arbiter: RTL and testbench

Shares the single-port synchronous SRAM behind the SoC's instruction memory between three requesters: CPU instruction fetch (IF), CPU load/store (LS), and the debug/loader port (DBG) that writes program images at boot. It sits between the core and the memory macro inside `top`. It grants at most one access per cycle, keeps back-to-back accesses fully pipelined, and routes each read response to its owner.

---
 rtl/nutty_mem_pkg.sv | 50 +++++
 rtl/mem_port_arbiter_pick.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nutty_mem_pkg.sv
// ---------------------------------------------------------------------------
// nutty_mem_pkg
// Shared definitions for the instruction-memory port arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default word-address and data widths
//   req_id_t                : requester identity, also the bit index of each
//                             requester in request/grant vectors
//   mem_cmd_t               : SRAM command bundle at the default widths
//   prio_pick               : first eligible requester in a given order
//   onehot_to_id            : one-hot grant vector -> requester identity
// ---------------------------------------------------------------------------
package nutty_mem_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    REQ_IF  = 2'd0,
    REQ_LS  = 2'd1,
    REQ_DBG = 2'd2
  } req_id_t;

  typedef struct packed {
    logic                    en;
    logic [DEF_DATA_W/8-1:0] we;
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_DATA_W-1:0]   wdata;
  } mem_cmd_t;

  // Grant the first eligible requester, scanning p0 then p1 then p2.
  function automatic logic [2:0] prio_pick(input logic [2:0] elig,
                                           input req_id_t p0,
                                           input req_id_t p1,
                                           input req_id_t p2);
    logic [2:0] g;
    g = 3'b000;
    if (elig[p0])      g[p0] = 1'b1;
    else if (elig[p1]) g[p1] = 1'b1;
    else if (elig[p2]) g[p2] = 1'b1;
    return g;
  endfunction

  function automatic req_id_t onehot_to_id(input logic [2:0] oh);
    req_id_t id;
    if (oh[REQ_DBG])     id = REQ_DBG;
    else if (oh[REQ_LS]) id = REQ_LS;
    else                 id = REQ_IF;
    return id;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection for the memory port arbiter.
//   req  : request vector, bit index = req_id_t
//   mask : per-requester enable (halt and reset masking applied by the top)
//   ptr  : last-granted requester (round-robin build only)
//   gnt  : one-hot grant, all zero when nobody is eligible
// Build option NUTTY_MEM_ARB_RR_EN: round-robin where the last-granted
// requester has the lowest priority. Without it, fixed DBG > LS > IF and
// ptr is ignored.
// ---------------------------------------------------------------------------
module mem_arb_pick
  import nutty_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] mask,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  logic [2:0] elig;
  assign elig = req & mask;

`ifdef NUTTY_MEM_ARB_RR_EN
  // Scan cyclically starting just after the last-granted requester.
  always_comb begin
    gnt = 3'b000;
    case (ptr)
      REQ_IF:  gnt = prio_pick(elig, REQ_LS,  REQ_DBG, REQ_IF);
      REQ_LS:  gnt = prio_pick(elig, REQ_DBG, REQ_IF,  REQ_LS);
      default: gnt = prio_pick(elig, REQ_IF,  REQ_LS,  REQ_DBG);
    endcase
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt = prio_pick(elig, REQ_DBG, REQ_LS, REQ_IF);
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous SRAM between CPU fetch (IF), CPU
// load/store (LS) and the debug/loader port (DBG). At most one access is
// granted per cycle; reads return one cycle later on the shared rdata bus,
// qualified by the owner's rvalid.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch read request        -> if_gnt, if_rvalid
//   ls_req/we/addr/wdata/wstrb load/store request      -> ls_gnt, ls_rvalid
//   dbg_req/we/addr/wdata    debug request (full word) -> dbg_gnt, dbg_rvalid
//   dbg_halt                 blocks IF and LS grants while high
//   rdata                    shared read data (mem_rdata pass-through)
//   mem_en/we/addr/wdata     SRAM command, mem_rdata SRAM read data
//
// Handshake: a requester holds req and its command stable until it samples
// gnt high at a rising edge; that edge accepts the access. gnt is
// combinational from req in the same cycle. Dropping req before gnt has no
// effect. Reads answer with rvalid exactly one cycle after acceptance;
// writes complete at acceptance and produce no rvalid.
//
// Build option NUTTY_MEM_ARB_RR_EN: round-robin arbitration with a
// last-granted pointer. Default build: fixed priority DBG > LS > IF.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import nutty_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,

  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wstrb,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,

  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_W-1:0]     dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  input  logic                  dbg_halt,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,

  output logic [DATA_W-1:0]     rdata,

  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [2:0] req_vec;
  logic [2:0] mask_vec;
  logic [2:0] gnt_vec;
  logic [1:0] ptr;
  logic       rd_gnt;
  logic       rsp_valid;
  req_id_t    rsp_owner;

  assign req_vec = {dbg_req, ls_req, if_req};

  // Reset blocks every grant combinationally; halt blocks only IF and LS.
  assign mask_vec = rst ? {1'b1, ~dbg_halt, ~dbg_halt} : 3'b000;

  mem_arb_pick u_pick (
    .req  (req_vec),
    .mask (mask_vec),
    .ptr  (ptr),
    .gnt  (gnt_vec)
  );

`ifdef NUTTY_MEM_ARB_RR_EN
  req_id_t last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= REQ_IF;
    end else if (|gnt_vec) begin
      last_q <= onehot_to_id(gnt_vec);
    end
  end

  assign ptr = last_q;
`else
  assign ptr = REQ_IF;
`endif

  assign if_gnt  = gnt_vec[REQ_IF];
  assign ls_gnt  = gnt_vec[REQ_LS];
  assign dbg_gnt = gnt_vec[REQ_DBG];

  // SRAM command mux. A zero-strobe LS write still occupies the slot but
  // drives mem_we = 0, so the macro performs a harmless read; it is not
  // tracked as a read because ls_we is set.
  always_comb begin
    mem_en    = |gnt_vec;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_gnt    = 1'b0;
    if (gnt_vec[REQ_DBG]) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = {STRB_W{dbg_we}};
      rd_gnt    = ~dbg_we;
    end else if (gnt_vec[REQ_LS]) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_we    = ls_we ? ls_wstrb : '0;
      rd_gnt    = ~ls_we;
    end else if (gnt_vec[REQ_IF]) begin
      mem_addr  = if_addr;
      rd_gnt    = 1'b1;
    end
  end

  // Fixed one-cycle read latency: the owner of the read granted at this
  // edge is the owner of mem_rdata in the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_owner <= REQ_IF;
    end else begin
      rsp_valid <= rd_gnt;
      rsp_owner <= onehot_to_id(gnt_vec);
    end
  end

  assign if_rvalid  = rsp_valid & (rsp_owner == REQ_IF);
  assign ls_rvalid  = rsp_valid & (rsp_owner == REQ_LS);
  assign dbg_rvalid = rsp_valid & (rsp_owner == REQ_DBG);
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with a behavioural SRAM, a
// reference model of the arbitration/response rules and an expected-response
// queue. Build option NUTTY_MEM_ARB_RR_EN selects the round-robin
// expectations.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          if_req, ls_req, ls_we, dbg_req, dbg_we, dbg_halt;
  logic [AW-1:0] if_addr, ls_addr, dbg_addr;
  logic [DW-1:0] ls_wdata, dbg_wdata;
  logic [SW-1:0] ls_wstrb;
  logic          if_gnt, ls_gnt, dbg_gnt, if_rvalid, ls_rvalid, dbg_rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en;
  logic [SW-1:0] mem_we;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_halt(dbg_halt), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < SW; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_we == '0) mem_rdata <= sram[mem_addr];
    end
  end

  // ---------------- driver ----------------
  typedef struct packed {
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [SW-1:0] ls_wstrb;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_halt;
  } drv_t;

  drv_t drv;

  function automatic drv_t idle_drv();
    drv_t d;
    d = '0;
    d.rst = 1'b1;
    return d;
  endfunction

  task automatic apply_drv();
    rst = drv.rst;
    if_req = drv.if_req;   if_addr = drv.if_addr;
    ls_req = drv.ls_req;   ls_we = drv.ls_we;     ls_addr = drv.ls_addr;
    ls_wdata = drv.ls_wdata; ls_wstrb = drv.ls_wstrb;
    dbg_req = drv.dbg_req; dbg_we = drv.dbg_we;   dbg_addr = drv.dbg_addr;
    dbg_wdata = drv.dbg_wdata; dbg_halt = drv.dbg_halt;
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  logic [DW+1:0] exp_q[$];           // {owner id, expected read data}
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int m_last = 0;                    // last granted requester (0 IF, 1 LS, 2 DBG)

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic bit elig(input int id);
    case (id)
      2:       return dbg_req == 1'b1;
      1:       return ls_req == 1'b1 && dbg_halt == 1'b0;
      default: return if_req == 1'b1 && dbg_halt == 1'b0;
    endcase
  endfunction

  // Predict this cycle's grant/command from the current inputs and compare,
  // check the response due from last cycle, then advance the model.
  task automatic model_check();
    int            w;
    logic [SW-1:0] ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    logic          wr;
    logic [DW+1:0] e;
    w = -1;
    if (rst) begin
`ifdef NUTTY_MEM_ARB_RR_EN
      for (int k = 1; k <= 3; k++) begin
        int id;
        id = (m_last + k) % 3;
        if (w < 0 && elig(id)) w = id;
      end
`else
      if (elig(2))      w = 2;
      else if (elig(1)) w = 1;
      else if (elig(0)) w = 0;
`endif
    end
    eaddr = '0; ewd = '0; ewe = '0; wr = 1'b0;
    case (w)
      0: eaddr = if_addr;
      1: begin eaddr = ls_addr;  ewd = ls_wdata;  wr = ls_we;  if (ls_we) ewe = ls_wstrb; end
      2: begin eaddr = dbg_addr; ewd = dbg_wdata; wr = dbg_we; if (dbg_we) ewe = '1; end
      default: ;
    endcase
    chk("gnt", 64'({dbg_gnt, ls_gnt, if_gnt}), (w < 0) ? 64'd0 : (64'd1 << w));
    chk("mem_en", 64'(mem_en), 64'(w >= 0));
    chk("mem_we", 64'(mem_we), 64'(ewe));
    if (w >= 0) chk("mem_addr", 64'(mem_addr), 64'(eaddr));
    if (wr) chk("mem_wdata", 64'(mem_wdata), 64'(ewd));

    if (!rst) exp_q.delete();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rvalid", 64'({dbg_rvalid, ls_rvalid, if_rvalid}), 64'd1 << e[DW+1:DW]);
      chk("rdata", 64'(rdata), 64'(e[DW-1:0]));
    end else begin
      chk("rvalid_idle", 64'({dbg_rvalid, ls_rvalid, if_rvalid}), 64'd0);
    end

    if (w >= 0) begin
      if (!wr) exp_q.push_back({w[1:0], ref_mem[eaddr]});
      else
        for (int b = 0; b < SW; b++)
          if (ewe[b]) ref_mem[eaddr][8*b +: 8] = ewd[8*b +: 8];
      m_last = w;
    end
    if (!rst) m_last = 0;
  endtask

  task automatic step();
    @(negedge clk);
    apply_drv();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    drv = idle_drv();
    drv.rst = 1'b0;
    step();
    step();
    drv.rst = 1'b1;
    step();
  endtask

  // ---------------- table vectors ----------------
  typedef struct packed {
    logic       if_req;
    logic       ls_req;
    logic       dbg_req;
    logic       halt;
    logic [2:0] exp_fx;   // {dbg, ls, if} grant, fixed priority
    logic [2:0] exp_rr;   // {dbg, ls, if} grant, round-robin from reset
  } vec_t;

  vec_t       tbl [12];
  logic [2:0] cont_exp [3];
  logic [2:0] exp_g;

  // ---------------- test ----------------
  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b001};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b010};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 3'b001};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 3'b010};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 3'b100};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 3'b100};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 3'b001};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 3'b100};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 3'b010};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 3'b100};
`ifdef NUTTY_MEM_ARB_RR_EN
    cont_exp[0] = 3'b010; cont_exp[1] = 3'b100; cont_exp[2] = 3'b001;
`else
    cont_exp[0] = 3'b100; cont_exp[1] = 3'b100; cont_exp[2] = 3'b100;
`endif

    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    drv = '0;
    apply_drv();

    // Reset with every requester active: nothing may be granted.
    drv.if_req = 1'b1; drv.ls_req = 1'b1; drv.dbg_req = 1'b1;
    step();
    step();
    chk("rst_gnt", 64'({dbg_gnt, ls_gnt, if_gnt}), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_rvalid", 64'({dbg_rvalid, ls_rvalid, if_rvalid}), 64'd0);
    drv = idle_drv();
    step();

    // Boot-image load through the debug port.
    for (int a = 0; a < 64; a++) begin
      drv = idle_drv();
      drv.dbg_req = 1'b1; drv.dbg_we = 1'b1; drv.dbg_addr = AW'(a);
      if (a == 4)                drv.dbg_wdata = 32'h0050_0093;
      else if (a == 16)          drv.dbg_wdata = 32'h0000_0000;
      else if (a >= 1 && a <= 3) drv.dbg_wdata = 32'hCAFE_0000 | DW'(a);
      else                       drv.dbg_wdata = $urandom();
      step();
    end

    // Single IF read.
    drv = idle_drv(); drv.if_req = 1'b1; drv.if_addr = 10'h004;
    step();
    chk("if_gnt_same_cycle", 64'(if_gnt), 64'd1);
    drv = idle_drv();
    step();
    chk("if_rvalid", 64'(if_rvalid), 64'd1);
    chk("if_rdata", 64'(rdata), 64'h0050_0093);
    chk("if_ls_rvalid_low", 64'(ls_rvalid), 64'd0);
    chk("if_dbg_rvalid_low", 64'(dbg_rvalid), 64'd0);

    // Byte write, then zero-strobe write, each followed by a read-back.
    drv = idle_drv(); drv.ls_req = 1'b1; drv.ls_we = 1'b1; drv.ls_addr = 10'h010;
    drv.ls_wdata = 32'hAABB_CCDD; drv.ls_wstrb = 4'b0010;
    step();
    chk("bw_mem_we", 64'(mem_we), 64'h2);
    drv = idle_drv();
    step();
    chk("bw_no_ls_rvalid", 64'(ls_rvalid), 64'd0);
    drv.ls_req = 1'b1; drv.ls_addr = 10'h010;
    step();
    drv = idle_drv();
    step();
    chk("bw_ls_rvalid", 64'(ls_rvalid), 64'd1);
    chk("bw_rdata", 64'(rdata), 64'h0000_CC00);
    drv.ls_req = 1'b1; drv.ls_we = 1'b1; drv.ls_addr = 10'h010;
    drv.ls_wdata = 32'hFFFF_FFFF; drv.ls_wstrb = 4'b0000;
    step();
    chk("zs_ls_gnt", 64'(ls_gnt), 64'd1);
    chk("zs_mem_we", 64'(mem_we), 64'd0);
    drv = idle_drv(); drv.ls_req = 1'b1; drv.ls_addr = 10'h010;
    step();
    chk("zs_no_ls_rvalid", 64'(ls_rvalid), 64'd0);
    drv = idle_drv();
    step();
    chk("zs_rdata", 64'(rdata), 64'h0000_CC00);

    // Halt with IF held; a debug write slips in mid-halt.
    drv = idle_drv(); drv.dbg_halt = 1'b1; drv.if_req = 1'b1; drv.if_addr = 10'h004;
    for (int c = 0; c < 5; c++) begin
      drv.dbg_req = (c == 2); drv.dbg_we = (c == 2);
      drv.dbg_addr = 10'h020; drv.dbg_wdata = 32'h1234_5678;
      step();
      chk("halt_if_gnt", 64'(if_gnt), 64'd0);
      if (c == 2) begin
        chk("halt_dbg_gnt", 64'(dbg_gnt), 64'd1);
        chk("halt_dbg_we", 64'(mem_we), 64'hF);
      end
    end
    drv.dbg_halt = 1'b0;
    step();
    chk("release_if_gnt", 64'(if_gnt), 64'd1);
    drv = idle_drv(); drv.dbg_req = 1'b1; drv.dbg_addr = 10'h020;
    step();
    chk("release_if_rvalid", 64'(if_rvalid), 64'd1);
    drv = idle_drv();
    step();
    chk("halt_dbg_rdata", 64'(rdata), 64'h1234_5678);

    // Reset asserted in the cycle an IF read is granted.
    drv = idle_drv(); drv.if_req = 1'b1; drv.if_addr = 10'h004;
    @(negedge clk);
    apply_drv();
    #1;
    chk("rmr_if_gnt", 64'(if_gnt), 64'd1);
    drv.rst = 1'b0;
    rst = 1'b0;
    #1;
    chk("rmr_gnt_in_rst", 64'(if_gnt), 64'd0);
    chk("rmr_mem_en", 64'(mem_en), 64'd0);
    exp_q.delete();
    m_last = 0;
    step();
    chk("rmr_no_rvalid", 64'(if_rvalid), 64'd0);
    step();
    drv = idle_drv();
    step();
    chk("rmr_idle_out", 64'({if_gnt, ls_gnt, dbg_gnt, if_rvalid, ls_rvalid, dbg_rvalid, mem_en}), 64'd0);
    step();
    chk("rmr_idle_out2", 64'({if_gnt, ls_gnt, dbg_gnt, if_rvalid, ls_rvalid, dbg_rvalid, mem_en, mem_we}), 64'd0);

    // Three-way read contention from reset.
    do_reset();
    drv = idle_drv();
    drv.if_req = 1'b1; drv.if_addr = 10'd5;
    drv.ls_req = 1'b1; drv.ls_addr = 10'd6;
    drv.dbg_req = 1'b1; drv.dbg_addr = 10'd7;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("contention_gnt", 64'({dbg_gnt, ls_gnt, if_gnt}), 64'(cont_exp[c]));
    end
    drv = idle_drv();
    step();

    // Table of grant patterns, applied back to back from reset.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drv = idle_drv();
      drv.if_req = tbl[i].if_req;   drv.if_addr = AW'(i);
      drv.ls_req = tbl[i].ls_req;   drv.ls_addr = AW'(i + 8);
      drv.dbg_req = tbl[i].dbg_req; drv.dbg_addr = AW'(i + 16);
      drv.dbg_halt = tbl[i].halt;
`ifdef NUTTY_MEM_ARB_RR_EN
      exp_g = tbl[i].exp_rr;
`else
      exp_g = tbl[i].exp_fx;
`endif
      step();
      chk("tbl_gnt", 64'({dbg_gnt, ls_gnt, if_gnt}), 64'(exp_g));
    end
    drv = idle_drv();
    step();

    // Back-to-back LS reads of addresses 1, 2, 3.
    for (int c = 0; c < 4; c++) begin
      drv = idle_drv();
      if (c < 3) begin drv.ls_req = 1'b1; drv.ls_addr = AW'(c + 1); end
      step();
      if (c < 3) chk("b2b_ls_gnt", 64'(ls_gnt), 64'd1);
      if (c > 0) begin
        chk("b2b_ls_rvalid", 64'(ls_rvalid), 64'd1);
        chk("b2b_rdata", 64'(rdata), 64'(32'hCAFE_0000 | DW'(c)));
      end
    end

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      drv.rst       = ($urandom_range(0, 49) != 0);
      drv.dbg_halt  = ($urandom_range(0, 4) == 0);
      drv.if_req    = 1'($urandom_range(0, 1));
      drv.if_addr   = AW'($urandom_range(0, 63));
      drv.ls_req    = 1'($urandom_range(0, 1));
      drv.ls_we     = 1'($urandom_range(0, 1));
      drv.ls_addr   = AW'($urandom_range(0, 63));
      drv.ls_wdata  = $urandom();
      drv.ls_wstrb  = SW'($urandom_range(0, 15));
      drv.dbg_req   = ($urandom_range(0, 3) == 0);
      drv.dbg_we    = 1'($urandom_range(0, 1));
      drv.dbg_addr  = AW'($urandom_range(0, 63));
      drv.dbg_wdata = $urandom();
      step();
    end
    drv = idle_drv();
    step();
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
